// File: rtl/uart_reg_responder.sv
// Byte-level register command responder behind a UART: decodes write (0x57,addr,data)
// and read (0x52,addr) frames against an 8-bit register file and returns one response byte.
module uart_reg_responder #(
    parameter int baudrate = 9600,
    parameter int clk_frec = 50000000,
    parameter int reg_num  = 16,
    parameter int to_bits  = 20
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic [7:0]             byte_rx,
    input  logic                   new_byte_rx,
    input  logic                   done_tx,
    output logic [7:0]             byte_tx,
    output logic                   start_tx,
    output logic [reg_num*8-1:0]   regs_out,
    output logic                   busy,
    output logic [7:0]             drop_cnt
);

    localparam longint TO_LIMIT_L = (longint'(to_bits) * longint'(clk_frec)) / longint'(baudrate);
    localparam int     TO_W       = $clog2(TO_LIMIT_L) + 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_LIMIT_L);
    localparam logic [8:0] REG_NUM_9 = 9'(reg_num);

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GET_ADDR = 3'd1;
    localparam logic [2:0] GET_DATA = 3'd2;
    localparam logic [2:0] TX_REQ   = 3'd3;
    localparam logic [2:0] TX_LOW   = 3'd4;
    localparam logic [2:0] TX_HIGH  = 3'd5;

    logic [2:0]      state_r, state_nxt_s;
    logic            is_wr_r, is_wr_nxt_s;
    logic [7:0]      addr_r, addr_nxt_s;
    logic            addr_ok_r, addr_ok_nxt_s;
    logic [7:0]      resp_r, resp_nxt_s;
    logic [TO_W-1:0] to_cnt_r;
    logic            wr_en_s;
    logic            load_tx_s;
    logic            addr_in_range_s;
    logic            timeout_s;
    logic            counting_s;
    logic            tx_phase_s;
    logic [7:0]      rd_val_s;

    assign addr_in_range_s = ({1'b0, byte_rx} < REG_NUM_9);
    assign timeout_s       = (to_cnt_r == TO_LIMIT);
    assign counting_s      = (state_r == GET_ADDR) || (state_r == GET_DATA);
    assign tx_phase_s      = (state_r == TX_REQ) || (state_r == TX_LOW) || (state_r == TX_HIGH);

    // Read-data mux indexed by the byte currently on byte_rx (the address strobe cycle)
    always_comb begin
        rd_val_s = 8'h00;
        for (int k = 0; k < reg_num; k++) begin
            rd_val_s = (byte_rx == 8'(k)) ? regs_out[k*8 +: 8] : rd_val_s;
        end
    end

    // Frame decoder next-state and response selection
    always_comb begin
        state_nxt_s   = state_r;
        is_wr_nxt_s   = is_wr_r;
        addr_nxt_s    = addr_r;
        addr_ok_nxt_s = addr_ok_r;
        resp_nxt_s    = resp_r;
        wr_en_s       = 1'b0;
        load_tx_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (new_byte_rx) begin
                    if (byte_rx == OP_WR) begin
                        state_nxt_s = GET_ADDR;
                        is_wr_nxt_s = 1'b1;
                    end else if (byte_rx == OP_RD) begin
                        state_nxt_s = GET_ADDR;
                        is_wr_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = TX_REQ;
                        resp_nxt_s  = RSP_NAK;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GET_ADDR: begin
                if (new_byte_rx) begin
                    addr_nxt_s    = byte_rx;
                    addr_ok_nxt_s = addr_in_range_s;
                    if (is_wr_r) begin
                        state_nxt_s = GET_DATA;
                    end else begin
                        state_nxt_s = TX_REQ;
                        resp_nxt_s  = addr_in_range_s ? rd_val_s : RSP_NAK;
                    end
                end else if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GET_ADDR;
                end
            end
            GET_DATA: begin
                // Data byte is always consumed; an out-of-range address only suppresses the write
                if (new_byte_rx) begin
                    wr_en_s     = addr_ok_r;
                    resp_nxt_s  = addr_ok_r ? RSP_ACK : RSP_NAK;
                    state_nxt_s = TX_REQ;
                end else if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GET_DATA;
                end
            end
            TX_REQ: begin
                if (done_tx) begin
                    load_tx_s   = 1'b1;
                    state_nxt_s = TX_LOW;
                end else begin
                    state_nxt_s = TX_REQ;
                end
            end
            TX_LOW: begin
                if (!done_tx) begin
                    state_nxt_s = TX_HIGH;
                end else begin
                    state_nxt_s = TX_LOW;
                end
            end
            TX_HIGH: begin
                if (done_tx) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = TX_HIGH;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control state, decoded frame fields and busy flag
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_r   <= IDLE;
            is_wr_r   <= 1'b0;
            addr_r    <= 8'h00;
            addr_ok_r <= 1'b0;
            resp_r    <= 8'h00;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            is_wr_r   <= is_wr_nxt_s;
            addr_r    <= addr_nxt_s;
            addr_ok_r <= addr_ok_nxt_s;
            resp_r    <= resp_nxt_s;
            busy      <= (state_nxt_s != IDLE);
        end
    end

    // Inter-byte timeout counter, active only while waiting for addr/data bytes
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            to_cnt_r <= '0;
        end else if (new_byte_rx) begin
            to_cnt_r <= '0;
        end else if (counting_s && !timeout_s) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= '0;
        end
    end

    // Register file write port
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            regs_out <= '0;
        end else begin
            for (int k = 0; k < reg_num; k++) begin
                if (wr_en_s && (addr_r == 8'(k))) begin
                    regs_out[k*8 +: 8] <= byte_rx;
                end
            end
        end
    end

    // Transmit handshake: one-cycle start pulse with byte_tx loaded on the same edge
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            start_tx <= 1'b0;
            byte_tx  <= 8'h00;
        end else begin
            start_tx <= load_tx_s;
            if (load_tx_s) begin
                byte_tx <= resp_r;
            end
        end
    end

    // Saturating count of bytes arriving while a response is pending or in flight
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            drop_cnt <= 8'h00;
        end else if (new_byte_rx && tx_phase_s && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Self-checking bench for uart_reg_responder: directed frame table, corner-case sequences
// and randomized frames compared against a register-array reference model.
module tb_uart_reg_responder;

    localparam int REG_NUM  = 16;
    localparam int TO_LIMIT = 200;   // 20 bit times * 1000 Hz / 100 baud

    logic                 clk = 1'b0;
    logic                 arstn = 1'b0;
    logic [7:0]           byte_rx = 8'h00;
    logic                 new_byte_rx = 1'b0;
    logic                 done_tx = 1'b1;
    logic [7:0]           byte_tx;
    logic                 start_tx;
    logic [REG_NUM*8-1:0] regs_out;
    logic                 busy;
    logic [7:0]           drop_cnt;

    uart_reg_responder #(
        .baudrate (100),
        .clk_frec (1000),
        .reg_num  (REG_NUM),
        .to_bits  (20)
    ) dut (
        .clk         (clk),
        .arstn       (arstn),
        .byte_rx     (byte_rx),
        .new_byte_rx (new_byte_rx),
        .done_tx     (done_tx),
        .byte_tx     (byte_tx),
        .start_tx    (start_tx),
        .regs_out    (regs_out),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] exp;
    } vec_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         pulse_cnt = 0;
    logic [7:0] reg_m [REG_NUM];

    always @(negedge clk) begin
        if (start_tx === 1'b1) pulse_cnt++;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_pack();
        logic [127:0] p = '0;
        for (int k = 0; k < REG_NUM; k++) p[k*8 +: 8] = reg_m[k];
        return p;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < REG_NUM; k++) reg_m[k] = 8'h00;
    endtask

    // Reference: what a complete frame does to the register array and what it answers
    task automatic model_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               output logic [7:0] rsp);
        if (b0 == 8'h57) begin
            if (int'(b1) < REG_NUM) begin
                reg_m[int'(b1)] = b2;
                rsp = 8'h06;
            end else begin
                rsp = 8'h15;
            end
        end else if (b0 == 8'h52) begin
            rsp = (int'(b1) < REG_NUM) ? reg_m[int'(b1)] : 8'h15;
        end else begin
            rsp = 8'h15;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        new_byte_rx = 1'b1;
        byte_rx     = b;
        @(negedge clk);
        new_byte_rx = 1'b0;
        byte_rx     = 8'($urandom_range(0, 255));
    endtask

    task automatic drive_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        if (b0 == 8'h57 || b0 == 8'h52) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send_byte(b1);
            if (b0 == 8'h57) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                send_byte(b2);
            end
        end
    endtask

    // Behaves as the UART transmitter for one response byte
    task automatic expect_resp(input string name, input logic [7:0] exp);
        int         n = 0;
        logic [7:0] held;
        logic       stable = 1'b1;
        while (start_tx !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({name, " start_tx"}, start_tx, 1);
        chk({name, " byte_tx"}, byte_tx, exp);
        held = byte_tx;
        @(negedge clk);
        chk({name, " pulse_width"}, start_tx, 0);
        done_tx = 1'b0;
        repeat ($urandom_range(1, 8)) begin
            @(negedge clk);
            if (byte_tx !== held) stable = 1'b0;
        end
        chk({name, " byte_tx_stable"}, stable, 1);
        done_tx = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk({name, " busy_low"}, busy, 0);
    endtask

    task automatic run_frame(input string name, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] exp);
        drive_frame(b0, b1, b2);
        chk({name, " regs"}, regs_out, model_pack());
        expect_resp(name, exp);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, " byte_tx"}, byte_tx, 0);
        chk({name, " start_tx"}, start_tx, 0);
        chk({name, " regs_out"}, regs_out, 0);
        chk({name, " busy"}, busy, 0);
        chk({name, " drop_cnt"}, drop_cnt, 0);
    endtask

    vec_t tbl [12];

    initial begin
        logic [7:0] m;
        logic [7:0] b0, b1, b2;
        int         p0;
        int         n;

        tbl[0]  = '{8'h57, 8'h03, 8'hA5, 8'h06};
        tbl[1]  = '{8'h52, 8'h03, 8'h00, 8'hA5};
        tbl[2]  = '{8'h41, 8'h00, 8'h00, 8'h15};
        tbl[3]  = '{8'h57, 8'h10, 8'h55, 8'h15};
        tbl[4]  = '{8'h52, 8'h10, 8'h00, 8'h15};
        tbl[5]  = '{8'h57, 8'h00, 8'h5A, 8'h06};
        tbl[6]  = '{8'h52, 8'h00, 8'h00, 8'h5A};
        tbl[7]  = '{8'h57, 8'h0F, 8'h52, 8'h06};
        tbl[8]  = '{8'h52, 8'h0F, 8'h00, 8'h52};
        tbl[9]  = '{8'h57, 8'h57, 8'h57, 8'h15};
        tbl[10] = '{8'h52, 8'h0F, 8'h00, 8'h52};
        tbl[11] = '{8'hFF, 8'h00, 8'h00, 8'h15};
        model_clear();

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        arstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            model_frame(tbl[i].b0, tbl[i].b1, tbl[i].b2, m);
            run_frame($sformatf("tbl%0d", i), tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].exp);
        end

        // Timeout after address byte: silent return to IDLE, then fresh opcode decode
        p0 = pulse_cnt;
        send_byte(8'h57);
        send_byte(8'h02);
        chk("timeout busy_start", busy, 1);
        repeat (TO_LIMIT - 10) @(negedge clk);
        chk("timeout busy_before", busy, 1);
        repeat (20) @(negedge clk);
        chk("timeout busy_after", busy, 0);
        chk("timeout no_pulse", pulse_cnt, p0);
        chk("timeout regs", regs_out, model_pack());
        model_frame(8'h52, 8'h02, 8'h00, m);
        run_frame("timeout resync", 8'h52, 8'h02, 8'h00, m);

        // Transmitter held busy in TX_REQ; bytes arriving meanwhile are dropped
        done_tx = 1'b0;
        p0 = pulse_cnt;
        model_frame(8'h52, 8'h03, 8'h00, m);
        drive_frame(8'h52, 8'h03, 8'h00);
        repeat (20) @(negedge clk);
        send_byte(8'h57);
        repeat (3) @(negedge clk);
        send_byte(8'h52);
        repeat (3) @(negedge clk);
        send_byte(8'h41);
        repeat (75) @(negedge clk);
        chk("hold no_pulse", pulse_cnt, p0);
        chk("hold start_tx", start_tx, 0);
        chk("hold busy", busy, 1);
        chk("hold drop_cnt", drop_cnt, 3);
        for (int i = 0; i < 253; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            @(negedge clk);
        end
        chk("drop saturate", drop_cnt, 255);
        chk("drop no_pulse", pulse_cnt, p0);
        done_tx = 1'b1;
        expect_resp("hold", m);
        chk("hold drop_after", drop_cnt, 255);
        chk("hold regs", regs_out, model_pack());

        // Reset mid-write after the address byte
        send_byte(8'h57);
        send_byte(8'h05);
        arstn = 1'b0;
        #1;
        chk_reset_outputs("rst_midwrite");
        model_clear();
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        model_frame(8'h52, 8'h00, 8'h00, m);
        run_frame("post_reset read", 8'h52, 8'h00, 8'h00, m);

        // Reset while start_tx is high
        model_frame(8'h57, 8'h01, 8'hC3, m);
        run_frame("pre_rst write", 8'h57, 8'h01, 8'hC3, m);
        drive_frame(8'h52, 8'h01, 8'h00);
        n = 0;
        while (start_tx !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("rst_midtx start_seen", start_tx, 1);
        chk("rst_midtx byte_tx", byte_tx, 8'hC3);
        arstn = 1'b0;
        #1;
        chk_reset_outputs("rst_midtx");
        model_clear();
        @(negedge clk);
        chk("rst_held start_tx", start_tx, 0);
        arstn = 1'b1;
        @(negedge clk);

        // Randomized frames against the reference model
        for (int i = 0; i < 40; i++) begin
            n  = $urandom_range(0, 99);
            b1 = 8'($urandom_range(0, 19));
            b2 = 8'($urandom_range(0, 255));
            if (n < 45) begin
                b0 = 8'h57;
            end else if (n < 90) begin
                b0 = 8'h52;
            end else begin
                b0 = 8'($urandom_range(0, 255));
                if (b0 == 8'h57 || b0 == 8'h52) b0 = 8'h3F;
            end
            model_frame(b0, b1, b2, m);
            run_frame($sformatf("rnd%0d", i), b0, b1, b2, m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
